ins_encoder_loader: RTL

- Encoder counterpart of the ID-stage control decoder.
- Accepts a stream of compact instruction commands (mnemonic code plus register, shamt and immediate fields) over a valid/ready handshake.
- Assembles each command into a 32-bit MIPS32 instruction word and writes it sequentially into instruction memory, one word per cycle.
- Used to load test programs and AES kernels into the I-memory before the core is released from reset.

---
 rtl/ins_encoder_loader_if.sv | 23 ++
 rtl/ins_encoder_loader.sv | 112 +++++++++++
 2 files changed

// File: rtl/ins_encoder_loader_if.sv
// Command channel of the instruction encoder/loader: a valid/ready handshake
// carrying one compact instruction command per transfer.
interface ins_encoder_loader_if;
  logic        in_valid;
  logic        out_ready;
  logic [4:0]  in_op;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [4:0]  in_shamt;
  logic [25:0] in_imm;
  logic        in_last;

  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_last,
    input  out_ready
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_last,
    output out_ready
  );
endinterface

// File: rtl/ins_encoder_loader.sv
// Instruction encoder/loader: turns compact commands into MIPS32 words and
// writes them sequentially into instruction memory, one word per cycle.
module ins_encoder_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_start,
  ins_encoder_loader_if.slave   cmd,
  output logic                  out_imem_we,
  output logic [ADDR_W-1:0]     out_imem_addr,
  output logic [31:0]           out_imem_wdata,
  output logic [ADDR_W:0]       out_count,
  output logic                  out_busy,
  output logic                  out_done,
  output logic                  out_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   ONE       = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   LAST_SLOT = {1'b0, {ADDR_W{1'b1}}};

  logic [1:0]        r_state;
  logic [ADDR_W:0]   r_count;
  logic              r_we;
  logic              r_last;
  logic [31:0]       r_wdata;

  logic              w_accept;
  logic              w_legal;
  logic              w_finish;
  logic [31:0]       w_word;

  assign cmd.out_ready = (r_state == S_RUN) && !in_start;
  assign w_accept      = cmd.in_valid && cmd.out_ready;

  // The write in flight ends the session if it is the last command or it
  // fills the final slot; a command accepted alongside it is then dropped.
  assign w_finish = r_we && (r_last || (r_count == LAST_SLOT));

  // Encode the presented command into a MIPS32 word, forcing unused fields to 0
  always_comb begin
    w_legal = 1'b1;
    w_word  = '0;
    case (cmd.in_op)
      5'd0:  w_word = {6'h00, cmd.in_rs, cmd.in_rt, cmd.in_rd, 5'd0, 6'h20};
      5'd1:  w_word = {6'h00, cmd.in_rs, cmd.in_rt, cmd.in_rd, 5'd0, 6'h22};
      5'd2:  w_word = {6'h00, cmd.in_rs, cmd.in_rt, cmd.in_rd, 5'd0, 6'h24};
      5'd3:  w_word = {6'h00, cmd.in_rs, cmd.in_rt, cmd.in_rd, 5'd0, 6'h25};
      5'd4:  w_word = {6'h00, cmd.in_rs, cmd.in_rt, cmd.in_rd, 5'd0, 6'h26};
      5'd5:  w_word = {6'h00, cmd.in_rs, cmd.in_rt, cmd.in_rd, 5'd0, 6'h2A};
      5'd6:  w_word = {6'h00, 5'd0, cmd.in_rt, cmd.in_rd, cmd.in_shamt, 6'h00};
      5'd7:  w_word = {6'h00, 5'd0, cmd.in_rt, cmd.in_rd, cmd.in_shamt, 6'h02};
      5'd8:  w_word = {6'h00, cmd.in_rs, 5'd0, 5'd0, 5'd0, 6'h08};
      5'd9:  w_word = {6'h08, cmd.in_rs, cmd.in_rt, cmd.in_imm[15:0]};
      5'd10: w_word = {6'h09, cmd.in_rs, cmd.in_rt, cmd.in_imm[15:0]};
      5'd11: w_word = {6'h0C, cmd.in_rs, cmd.in_rt, cmd.in_imm[15:0]};
      5'd12: w_word = {6'h0D, cmd.in_rs, cmd.in_rt, cmd.in_imm[15:0]};
      5'd13: w_word = {6'h0E, cmd.in_rs, cmd.in_rt, cmd.in_imm[15:0]};
      5'd14: w_word = {6'h0F, 5'd0, cmd.in_rt, cmd.in_imm[15:0]};
      5'd15: w_word = {6'h23, cmd.in_rs, cmd.in_rt, cmd.in_imm[15:0]};
      5'd16: w_word = {6'h2B, cmd.in_rs, cmd.in_rt, cmd.in_imm[15:0]};
      5'd17: w_word = {6'h04, cmd.in_rs, cmd.in_rt, cmd.in_imm[15:0]};
      5'd18: w_word = {6'h05, cmd.in_rs, cmd.in_rt, cmd.in_imm[15:0]};
      5'd19: w_word = {6'h02, cmd.in_imm};
      5'd20: w_word = {6'h03, cmd.in_imm};
      default: w_legal = 1'b0;
    endcase
  end

  // Session control, write pipeline and word counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_we    <= 1'b0;
      r_last  <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_we <= w_accept && w_legal && !w_finish;
      if (w_accept) begin
        r_wdata <= w_word;
        r_last  <= cmd.in_last;
      end
      // in_start overrides everything except the write already in flight,
      // which still reaches memory this cycle at its old address.
      if (in_start) begin
        r_state <= S_RUN;
        r_count <= '0;
      end else begin
        if (r_we) r_count <= r_count + ONE;
        if (w_finish)                   r_state <= r_last ? S_DONE : S_ERR;
        else if (w_accept && !w_legal)  r_state <= S_ERR;
      end
    end
  end

  assign out_imem_we    = r_we;
  assign out_imem_addr  = r_we ? (BASE + r_count[ADDR_W-1:0]) : '0;
  assign out_imem_wdata = r_wdata;
  assign out_count      = r_count;
  assign out_busy       = (r_state == S_RUN);
  assign out_done       = (r_state == S_DONE);
  assign out_err        = (r_state == S_ERR);

endmodule
